// File: rtl/example_mac_pkg.sv
// Shared types and helpers for the example_mac_pipe multiply-accumulate engine.
//   p_width  : exact product width of a signed A by a (un)signed B operand
//   lane_lo  : low bit index of a lane inside a flattened multi-lane bus
//   sat_add  : clamps an exact (wide) sum into ACC_WIDTH bits, flags overflow
package example_mac_pkg;

  // Widest accumulator the saturation helper can clamp.
  localparam int unsigned MAX_ACC_WIDTH = 64;

  // Sideband travelling alongside the operands through the pipe.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } beat_side_t;

  typedef struct packed {
    logic                     ovf;
    logic [MAX_ACC_WIDTH-1:0] value;
  } sat_res_t;

  function automatic int unsigned p_width(input int unsigned a_w, input int unsigned b_w);
    return a_w + b_w;
  endfunction

  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned w);
    return lane * w;
  endfunction

  // sum is the exact, sign-extended result of an ACC_WIDTH-bit add.
  function automatic sat_res_t sat_add(input logic signed [MAX_ACC_WIDTH:0] sum,
                                       input int unsigned               acc_w);
    logic signed [MAX_ACC_WIDTH:0] one;
    logic signed [MAX_ACC_WIDTH:0] hi;
    logic signed [MAX_ACC_WIDTH:0] lo;
    sat_res_t r;
    one     = {{MAX_ACC_WIDTH{1'b0}}, 1'b1};
    hi      = (one <<< (acc_w - 1)) - one;
    lo      = -(one <<< (acc_w - 1));
    r.ovf   = 1'b0;
    r.value = sum[MAX_ACC_WIDTH-1:0];
    if (sum > hi) begin
      r.ovf   = 1'b1;
      r.value = hi[MAX_ACC_WIDTH-1:0];
    end else if (sum < lo) begin
      r.ovf   = 1'b1;
      r.value = lo[MAX_ACC_WIDTH-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/example_mac_lane.sv
// One MAC lane: operand extension, NUM_STAGE multiplier pipe, accumulator,
// sticky saturation flag and the lane's slice of the output register.
//   clk, rst_n          : clock, async active-low reset
//   adv                 : pipe advance enable (shared backpressure)
//   in_a, in_b          : lane operands at pipe entry
//   acc_en              : a valid beat sits at pipe end and adv=1
//   acc_first, acc_last : burst delimiters of that beat
//   out_acc, out_sat    : registered burst result and saturation flag
module example_mac_lane
  import example_mac_pkg::*;
#(
  parameter int unsigned A_WIDTH   = 14,
  parameter int unsigned B_WIDTH   = 7,
  parameter bit          B_SIGNED  = 1'b0,
  parameter int unsigned NUM_STAGE = 3,
  parameter int unsigned ACC_WIDTH = 32,
  parameter bit          SAT_EN    = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 adv,
  input  logic [A_WIDTH-1:0]   in_a,
  input  logic [B_WIDTH-1:0]   in_b,
  input  logic                 acc_en,
  input  logic                 acc_first,
  input  logic                 acc_last,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic                 out_sat
);

  localparam int unsigned P_WIDTH = p_width(A_WIDTH, B_WIDTH);

  logic signed [A_WIDTH-1:0]   a_q;
  logic signed [B_WIDTH:0]     b_q;
  logic signed [P_WIDTH-1:0]   prod;
  logic signed [P_WIDTH-1:0]   p_end;

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] out_acc_q, out_acc_d;
  logic                        sat_q, sat_d;
  logic                        out_sat_q, out_sat_d;

  logic signed [ACC_WIDTH-1:0] base;
  logic signed [ACC_WIDTH-1:0] p_ext;
  logic signed [ACC_WIDTH:0]   sum_raw;
  logic signed [ACC_WIDTH-1:0] sum_val;
  logic                        flag;
  sat_res_t                    sres;

  // Datapath registers carry no reset so they map onto DSP pipeline
  // registers; the stage valids in the top decide whether they matter.
  always_ff @(posedge clk) begin
    if (adv) begin
      a_q <= in_a;
      b_q <= B_SIGNED ? {in_b[B_WIDTH-1], in_b} : {1'b0, in_b};
    end
  end

  // A_WIDTH+B_WIDTH bits hold every product exactly, also for zero-extended B.
  assign prod = a_q * b_q;

  if (NUM_STAGE == 1) begin : g_pipe1
    assign p_end = prod;
  end else begin : g_pipen
    logic signed [P_WIDTH-1:0] pp_q [NUM_STAGE-1];
    always_ff @(posedge clk) begin
      if (adv) begin
        pp_q[0] <= prod;
        for (int unsigned k = 1; k < NUM_STAGE - 1; k++) pp_q[k] <= pp_q[k-1];
      end
    end
    assign p_end = pp_q[NUM_STAGE-2];
  end

  always_comb begin
    base    = acc_first ? '0 : acc_q;
    p_ext   = (ACC_WIDTH)'(p_end);
    sum_raw = $signed({base[ACC_WIDTH-1], base}) + $signed({p_ext[ACC_WIDTH-1], p_ext});
    sres    = sat_add((MAX_ACC_WIDTH+1)'(sum_raw), ACC_WIDTH);
    if (SAT_EN) begin
      sum_val = (ACC_WIDTH)'(sres.value);
      flag    = (acc_first ? 1'b0 : sat_q) | sres.ovf;
    end else begin
      sum_val = sum_raw[ACC_WIDTH-1:0];
      flag    = 1'b0;
    end

    acc_d     = acc_q;
    sat_d     = sat_q;
    out_acc_d = out_acc_q;
    out_sat_d = out_sat_q;
    if (acc_en) begin
      acc_d = sum_val;
      sat_d = flag;
      if (acc_last) begin
        out_acc_d = sum_val;
        out_sat_d = flag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      sat_q     <= 1'b0;
      out_acc_q <= '0;
      out_sat_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      sat_q     <= sat_d;
      out_acc_q <= out_acc_d;
      out_sat_q <= out_sat_d;
    end
  end

  assign out_acc = out_acc_q;
  assign out_sat = out_sat_q;

endmodule

// File: rtl/example_mac_pipe.sv
// Pipelined multi-lane multiply-accumulate engine. Each lane multiplies a
// signed A by an (un)signed B through NUM_STAGE registers and accumulates
// over first/last delimited bursts; results leave through a valid/ready
// register whose backpressure freezes the whole pipe.
//   ap_clk, ap_rst_n          : clock, async active-low reset
//   in_valid/in_ready         : input beat handshake
//   in_a, in_b                : lane-packed operands
//   in_first, in_last         : burst delimiters
//   out_valid/out_ready       : result handshake
//   out_acc, out_sat          : lane-packed burst results and saturation flags
module example_mac_pipe
  import example_mac_pkg::*;
#(
  parameter int unsigned A_WIDTH   = 14,
  parameter int unsigned B_WIDTH   = 7,
  parameter bit          B_SIGNED  = 1'b0,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned NUM_STAGE = 3,
  parameter int unsigned ACC_WIDTH = 32,
  parameter bit          SAT_EN    = 1'b0
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_CH*A_WIDTH-1:0]   in_a,
  input  logic [NUM_CH*B_WIDTH-1:0]   in_b,
  input  logic                        in_first,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_CH*ACC_WIDTH-1:0] out_acc,
  output logic [NUM_CH-1:0]           out_sat
);

  beat_side_t side_q [NUM_STAGE];
  beat_side_t side_d [NUM_STAGE];
  beat_side_t side_end;
  logic       adv;
  logic       acc_en;
  logic       out_valid_q, out_valid_d;

  // A result stuck in the output register stalls every stage.
  assign adv      = !(out_valid_q && !out_ready);
  assign in_ready = adv;
  assign side_end = side_q[NUM_STAGE-1];
  assign acc_en   = adv && side_end.valid;

  always_comb begin
    side_d = side_q;
    if (adv) begin
      side_d[0] = {in_valid, in_first, in_last};
      for (int unsigned k = 1; k < NUM_STAGE; k++) side_d[k] = side_q[k-1];
    end
    // With adv=1 the current result is either absent or being taken, so
    // out_valid simply follows whether a last beat accumulates now.
    out_valid_d = adv ? (side_end.valid && side_end.last) : out_valid_q;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int unsigned k = 0; k < NUM_STAGE; k++) side_q[k] <= '0;
      out_valid_q <= 1'b0;
    end else begin
      side_q      <= side_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    example_mac_lane #(
      .A_WIDTH  (A_WIDTH),
      .B_WIDTH  (B_WIDTH),
      .B_SIGNED (B_SIGNED),
      .NUM_STAGE(NUM_STAGE),
      .ACC_WIDTH(ACC_WIDTH),
      .SAT_EN   (SAT_EN)
    ) u_lane (
      .clk      (ap_clk),
      .rst_n    (ap_rst_n),
      .adv      (adv),
      .in_a     (in_a[lane_lo(i, A_WIDTH) +: A_WIDTH]),
      .in_b     (in_b[lane_lo(i, B_WIDTH) +: B_WIDTH]),
      .acc_en   (acc_en),
      .acc_first(side_end.first),
      .acc_last (side_end.last),
      .out_acc  (out_acc[lane_lo(i, ACC_WIDTH) +: ACC_WIDTH]),
      .out_sat  (out_sat[i])
    );
  end

endmodule

// File: tb/tb_example_mac_pipe.sv
module tb_example_mac_pipe;

  localparam int NCH  = 4;
  localparam int AW   = 14;
  localparam int BW   = 7;
  localparam int ACCW = 32;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Default-parameter DUT
  logic                  in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic                  in_ready, out_valid;
  logic                  out_ready = 1'b1;
  logic [NCH*AW-1:0]     in_a = '0;
  logic [NCH*BW-1:0]     in_b = '0;
  logic [NCH*ACCW-1:0]   out_acc;
  logic [NCH-1:0]        out_sat;

  example_mac_pipe dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_sat(out_sat)
  );

  // Single-lane variants sharing one stimulus bus
  logic          x_valid = 1'b0, x_first = 1'b0, x_last = 1'b0;
  logic [AW-1:0] x_a = '0;
  logic [BW-1:0] x_b = '0;
  logic          s_ready, s_valid, s_sat;
  logic [20:0]   s_acc;
  logic          w_ready, w_valid, w_sat;
  logic [20:0]   w_acc;
  logic          g_ready, g_valid, g_sat;
  logic [31:0]   g_acc;

  example_mac_pipe #(.NUM_CH(1), .ACC_WIDTH(21), .SAT_EN(1'b1)) dut_sat (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(x_valid), .in_ready(s_ready), .in_a(x_a), .in_b(x_b),
    .in_first(x_first), .in_last(x_last),
    .out_valid(s_valid), .out_ready(1'b1), .out_acc(s_acc), .out_sat(s_sat)
  );

  example_mac_pipe #(.NUM_CH(1), .ACC_WIDTH(21), .SAT_EN(1'b0)) dut_wrap (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(x_valid), .in_ready(w_ready), .in_a(x_a), .in_b(x_b),
    .in_first(x_first), .in_last(x_last),
    .out_valid(w_valid), .out_ready(1'b1), .out_acc(w_acc), .out_sat(w_sat)
  );

  example_mac_pipe #(.NUM_CH(1), .B_SIGNED(1'b1)) dut_bsgn (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(x_valid), .in_ready(g_ready), .in_a(x_a), .in_b(x_b),
    .in_first(x_first), .in_last(x_last),
    .out_valid(g_valid), .out_ready(1'b1), .out_acc(g_acc), .out_sat(g_sat)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic longint lane_acc(input logic [NCH*ACCW-1:0] v, input int k);
    logic signed [ACCW-1:0] t;
    t = v[k*ACCW +: ACCW];
    return t;
  endfunction

  task automatic set_lane(input int k, input int a, input int b);
    in_a[k*AW +: AW] = a[AW-1:0];
    in_b[k*BW +: BW] = b[BW-1:0];
  endtask

  // Present a beat on the default DUT and hold it until accepted.
  task automatic send_beat(input logic f, input logic l);
    int unsigned t;
    t = 0;
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    @(negedge ap_clk);
    while (!in_ready && t < 200) begin
      @(negedge ap_clk);
      t++;
    end
    if (!in_ready) check("send_timeout", in_ready, 1);
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_x(input int a, input int b, input logic f, input logic l);
    x_a     = a[AW-1:0];
    x_b     = b[BW-1:0];
    x_first = f;
    x_last  = l;
    x_valid = 1'b1;
    @(posedge ap_clk);
    #1;
    x_valid = 1'b0;
  endtask

  // Result capture on the default DUT
  logic [NCH*ACCW-1:0] res_q[$];
  logic [NCH-1:0]      rsat_q[$];
  int unsigned         rcyc_q[$];
  int unsigned         cyc = 0;

  always @(posedge ap_clk) cyc <= cyc + 1;

  always @(negedge ap_clk) begin
    if (ap_rst_n && out_valid && out_ready) begin
      res_q.push_back(out_acc);
      rsat_q.push_back(out_sat);
      rcyc_q.push_back(cyc);
    end
  end

  task automatic clear_results();
    res_q.delete();
    rsat_q.delete();
    rcyc_q.delete();
  endtask

  task automatic wait_results(input int n, input string tag);
    int unsigned t;
    t = 0;
    while (res_q.size() < n && t < 300) begin
      @(posedge ap_clk);
      t++;
    end
    check(tag, res_q.size(), n);
  endtask

  function automatic int bp_a(input int i, input int k);
    return ((k % 2) ? -1 : 1) * (i + 1) * (k + 1) * 100;
  endfunction

  function automatic int bp_b(input int i, input int k);
    return 10 * i + k + 1;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned cnt;
    logic [NCH*ACCW-1:0] r;

    // Reset state
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_acc_l0", lane_acc(out_acc, 0), 0);
    check("rst_acc_l3", lane_acc(out_acc, 3), 0);
    check("rst_sat", out_sat, 0);
    ap_rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_x_ready", {s_ready, w_ready, g_ready}, 3'b111);
    @(posedge ap_clk);
    #1;

    // Single product, latency
    set_lane(0, -8192, 127);
    send_beat(1'b1, 1'b1);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge ap_clk);
      #1;
      cnt++;
    end
    check("t1_latency", cnt, 3);
    check("t1_acc_l0", lane_acc(out_acc, 0), -1040384);
    check("t1_acc_l1", lane_acc(out_acc, 1), 0);
    check("t1_sat", out_sat, 0);
    @(posedge ap_clk);
    #1;
    clear_results();

    // 3-beat burst followed immediately by a single-beat burst
    set_lane(0, 100, 3);  send_beat(1'b1, 1'b0);
    set_lane(0, -50, 2);  send_beat(1'b0, 1'b0);
    set_lane(0, 7, 127);  send_beat(1'b0, 1'b1);
    set_lane(0, 1, 1);    send_beat(1'b1, 1'b1);
    wait_results(2, "burst_count");
    if (res_q.size() >= 2) begin
      check("burst_res0", lane_acc(res_q[0], 0), 1089);
      check("burst_res1", lane_acc(res_q[1], 0), 1);
      check("burst_no_bubble", rcyc_q[1] - rcyc_q[0], 1);
    end
    repeat (2) @(posedge ap_clk);
    #1;
    clear_results();

    // Continuous input with 10 cycles of output backpressure
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          for (int k = 0; k < NCH; k++) set_lane(k, bp_a(i, k), bp_b(i, k));
          send_beat(1'b1, 1'b1);
        end
      end
      begin
        int unsigned t;
        t = 0;
        @(posedge ap_clk);
        #1;
        while (!out_valid && t < 50) begin
          @(posedge ap_clk);
          #1;
          t++;
        end
        out_ready = 1'b0;
        #1;
        check("bp_in_ready_low", in_ready, 0);
        repeat (10) @(posedge ap_clk);
        #2;
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_in_ready", in_ready, 0);
        check("bp_hold_l0", lane_acc(out_acc, 0), longint'(bp_a(0, 0)) * bp_b(0, 0));
        check("bp_hold_l3", lane_acc(out_acc, 3), longint'(bp_a(0, 3)) * bp_b(0, 3));
        out_ready = 1'b1;
      end
    join
    wait_results(8, "bp_count");
    for (int i = 0; i < 8 && i < res_q.size(); i++) begin
      r = res_q[i];
      for (int k = 0; k < NCH; k++)
        check($sformatf("bp_res%0d_l%0d", i, k), lane_acc(r, k), longint'(bp_a(i, k)) * bp_b(i, k));
    end
    repeat (2) @(posedge ap_clk);
    #1;
    clear_results();

    // Reset while a result is pending and two beats are in flight
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    set_lane(0, 2, 2);  send_beat(1'b1, 1'b1);
    set_lane(0, 3, 3);  send_beat(1'b1, 1'b0);
    set_lane(0, 4, 4);  send_beat(1'b0, 1'b0);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge ap_clk);
      #1;
      cnt++;
    end
    check("rst_mid_pending", out_valid, 1);
    ap_rst_n = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_acc", lane_acc(out_acc, 0), 0);
    out_ready = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    repeat (5) @(posedge ap_clk);
    #1;
    check("rst_mid_no_stale", res_q.size(), 0);
    set_lane(0, 10, 10);
    send_beat(1'b0, 1'b1);
    wait_results(1, "rst_after_count");
    if (res_q.size() >= 1) begin
      check("rst_after_acc", lane_acc(res_q[0], 0), 100);
      check("rst_after_sat", rsat_q[0], 0);
    end

    // Saturating vs wrapping accumulate, 21-bit accumulator
    send_x(8191, 127, 1'b1, 1'b0);
    send_x(8191, 127, 1'b0, 1'b1);
    cnt = 0;
    while (!s_valid && cnt < 20) begin
      @(posedge ap_clk);
      #1;
      cnt++;
    end
    check("sat_valid", s_valid, 1);
    check("sat_acc", longint'($signed(s_acc)), 1048575);
    check("sat_flag", s_sat, 1);
    check("wrap_valid", w_valid, 1);
    check("wrap_acc", longint'($signed(w_acc)), -16638);
    check("wrap_flag", w_sat, 0);

    // Signed vs unsigned B
    send_x(5, 127, 1'b1, 1'b1);
    cnt = 0;
    while (!g_valid && cnt < 20) begin
      @(posedge ap_clk);
      #1;
      cnt++;
    end
    check("bsgn_valid", g_valid, 1);
    check("bsgn_acc", longint'($signed(g_acc)), -5);
    check("bsgn_sat", g_sat, 0);
    check("bunsgn_acc", longint'($signed(w_acc)), 635);

    repeat (2) @(posedge ap_clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
